// File: rtl/rvspec_stepper_if.sv
// Fetch and data memory handshake bundle between the stepper (master) and
// the instruction/data memories (slave).
interface rvspec_stepper_if;
   logic        imem_valid;
   logic        imem_ready;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        dmem_valid;
   logic        dmem_ready;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;

   modport master (
      output imem_valid, imem_addr,
      input  imem_ready, imem_rdata,
      output dmem_valid, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  imem_valid, imem_addr,
      output imem_ready, imem_rdata,
      input  dmem_valid, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/rvspec_stepper.sv
// Sequential driver around the combinational rvspec core: holds pc and x1..x31,
// walks each instruction through fetch/exec/load/store and emits one RVFI record.
module rvspec_stepper #(
   parameter logic [31:0] RESET_PC     = 32'h0,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0,
   parameter bit          HALT_ON_TRAP = 1'b1,
   parameter int          ORDER_WIDTH  = 64
) (
   input  logic                   clk,
   input  logic                   arst,
   rvspec_stepper_if.master       mem,
   output logic [31:0]            core_insn,
   output logic [31:0]            core_pc,
   output logic [991:0]           core_regs,
   output logic [31:0]            core_ld_data,
   input  logic [31:0]            core_next_pc,
   input  logic [991:0]           core_next_regs,
   input  logic                   core_ld_valid,
   input  logic                   core_st_valid,
   input  logic [31:0]            core_ld_addr,
   input  logic [31:0]            core_st_addr,
   input  logic [31:0]            core_st_data,
   input  logic                   core_trap,
   output logic                   rvfi_valid,
   output logic [ORDER_WIDTH-1:0] rvfi_order,
   output logic [31:0]            rvfi_insn,
   output logic [31:0]            rvfi_pc_rdata,
   output logic [31:0]            rvfi_pc_wdata,
   output logic                   rvfi_trap,
   output logic                   rvfi_halt,
   output logic [31:0]            rvfi_mem_addr,
   output logic [31:0]            rvfi_mem_rdata,
   output logic [31:0]            rvfi_mem_wdata,
   output logic [3:0]             rvfi_mem_rmask,
   output logic [3:0]             rvfi_mem_wmask
);

   typedef enum logic [2:0] {
      S_FETCH, S_EXEC, S_LOAD, S_STORE, S_COMMIT, S_TRAP, S_HALT
   } state_e;

   state_e                 state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [31:0]            insn_q, insn_d;
   logic [991:0]           regs_q, regs_d;
   logic [31:0]            ld_data_q, ld_data_d;
   logic [ORDER_WIDTH-1:0] order_q, order_d;
   logic                   ld_used_q, ld_used_d;
   logic                   st_used_q, st_used_d;
   logic [31:0]            ld_addr_q, ld_addr_d;
   logic [31:0]            st_addr_q, st_addr_d;
   logic [31:0]            st_data_q, st_data_d;

   logic                   rvfi_valid_q, rvfi_valid_d;
   logic [ORDER_WIDTH-1:0] rvfi_order_q, rvfi_order_d;
   logic [31:0]            rvfi_insn_q, rvfi_insn_d;
   logic [31:0]            rvfi_pc_rdata_q, rvfi_pc_rdata_d;
   logic [31:0]            rvfi_pc_wdata_q, rvfi_pc_wdata_d;
   logic                   rvfi_trap_q, rvfi_trap_d;
   logic [31:0]            rvfi_mem_addr_q, rvfi_mem_addr_d;
   logic [31:0]            rvfi_mem_rdata_q, rvfi_mem_rdata_d;
   logic [31:0]            rvfi_mem_wdata_q, rvfi_mem_wdata_d;
   logic [3:0]             rvfi_mem_rmask_q, rvfi_mem_rmask_d;
   logic [3:0]             rvfi_mem_wmask_q, rvfi_mem_wmask_d;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q          <= S_FETCH;
         pc_q             <= RESET_PC;
         insn_q           <= '0;
         regs_q           <= '0;
         ld_data_q        <= '0;
         order_q          <= '0;
         ld_used_q        <= 1'b0;
         st_used_q        <= 1'b0;
         ld_addr_q        <= '0;
         st_addr_q        <= '0;
         st_data_q        <= '0;
         rvfi_valid_q     <= 1'b0;
         rvfi_order_q     <= '0;
         rvfi_insn_q      <= '0;
         rvfi_pc_rdata_q  <= '0;
         rvfi_pc_wdata_q  <= '0;
         rvfi_trap_q      <= 1'b0;
         rvfi_mem_addr_q  <= '0;
         rvfi_mem_rdata_q <= '0;
         rvfi_mem_wdata_q <= '0;
         rvfi_mem_rmask_q <= '0;
         rvfi_mem_wmask_q <= '0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         insn_q           <= insn_d;
         regs_q           <= regs_d;
         ld_data_q        <= ld_data_d;
         order_q          <= order_d;
         ld_used_q        <= ld_used_d;
         st_used_q        <= st_used_d;
         ld_addr_q        <= ld_addr_d;
         st_addr_q        <= st_addr_d;
         st_data_q        <= st_data_d;
         rvfi_valid_q     <= rvfi_valid_d;
         rvfi_order_q     <= rvfi_order_d;
         rvfi_insn_q      <= rvfi_insn_d;
         rvfi_pc_rdata_q  <= rvfi_pc_rdata_d;
         rvfi_pc_wdata_q  <= rvfi_pc_wdata_d;
         rvfi_trap_q      <= rvfi_trap_d;
         rvfi_mem_addr_q  <= rvfi_mem_addr_d;
         rvfi_mem_rdata_q <= rvfi_mem_rdata_d;
         rvfi_mem_wdata_q <= rvfi_mem_wdata_d;
         rvfi_mem_rmask_q <= rvfi_mem_rmask_d;
         rvfi_mem_wmask_q <= rvfi_mem_wmask_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      insn_d           = insn_q;
      regs_d           = regs_q;
      ld_data_d        = ld_data_q;
      order_d          = order_q;
      ld_used_d        = ld_used_q;
      st_used_d        = st_used_q;
      ld_addr_d        = ld_addr_q;
      st_addr_d        = st_addr_q;
      st_data_d        = st_data_q;
      // Record fields are zero outside the retirement pulse.
      rvfi_valid_d     = 1'b0;
      rvfi_order_d     = '0;
      rvfi_insn_d      = '0;
      rvfi_pc_rdata_d  = '0;
      rvfi_pc_wdata_d  = '0;
      rvfi_trap_d      = 1'b0;
      rvfi_mem_addr_d  = '0;
      rvfi_mem_rdata_d = '0;
      rvfi_mem_wdata_d = '0;
      rvfi_mem_rmask_d = '0;
      rvfi_mem_wmask_d = '0;

      unique case (state_q)
         S_FETCH: begin
            if (pc_q[1:0] != 2'b00) begin
               insn_d    = '0;
               ld_used_d = 1'b0;
               st_used_d = 1'b0;
               state_d   = S_TRAP;
            end else if (mem.imem_ready) begin
               insn_d    = mem.imem_rdata;
               ld_used_d = 1'b0;
               st_used_d = 1'b0;
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            if (core_trap)          state_d = S_TRAP;
            else if (core_ld_valid) state_d = S_LOAD;
            else if (core_st_valid) state_d = S_STORE;
            else                    state_d = S_COMMIT;
         end
         S_LOAD: begin
            if (mem.dmem_ready) begin
               ld_data_d = mem.dmem_rdata;
               ld_used_d = 1'b1;
               ld_addr_d = core_ld_addr;
               state_d   = core_st_valid ? S_STORE : S_COMMIT;
            end
         end
         S_STORE: begin
            if (mem.dmem_ready) begin
               st_used_d = 1'b1;
               st_addr_d = core_st_addr;
               st_data_d = core_st_data;
               state_d   = S_COMMIT;
            end
         end
         S_COMMIT: begin
            pc_d             = core_next_pc;
            regs_d           = core_next_regs;
            rvfi_valid_d     = 1'b1;
            rvfi_order_d     = order_q;
            rvfi_insn_d      = insn_q;
            rvfi_pc_rdata_d  = pc_q;
            rvfi_pc_wdata_d  = core_next_pc;
            rvfi_mem_addr_d  = st_used_q ? st_addr_q : (ld_used_q ? ld_addr_q : 32'h0);
            rvfi_mem_rdata_d = ld_used_q ? ld_data_q : 32'h0;
            rvfi_mem_wdata_d = st_used_q ? st_data_q : 32'h0;
            rvfi_mem_rmask_d = {4{ld_used_q}};
            rvfi_mem_wmask_d = {4{st_used_q}};
            order_d          = order_q + ORDER_WIDTH'(1);
            state_d          = S_FETCH;
         end
         S_TRAP: begin
            rvfi_valid_d    = 1'b1;
            rvfi_order_d    = order_q;
            rvfi_insn_d     = insn_q;
            rvfi_pc_rdata_d = pc_q;
            rvfi_trap_d     = 1'b1;
            order_d         = order_q + ORDER_WIDTH'(1);
            if (HALT_ON_TRAP) begin
               state_d = S_HALT;
            end else begin
               pc_d    = TRAP_VECTOR;
               state_d = S_FETCH;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   always_comb begin
      // Gated by arst so no fetch is offered while reset is still held.
      mem.imem_valid = (state_q == S_FETCH) && (pc_q[1:0] == 2'b00) && !arst;
      mem.imem_addr  = pc_q;
      mem.dmem_valid = (state_q == S_LOAD) || (state_q == S_STORE);
      mem.dmem_we    = (state_q == S_STORE);
      mem.dmem_addr  = '0;
      mem.dmem_wdata = '0;
      if (state_q == S_LOAD) begin
         mem.dmem_addr = core_ld_addr;
      end else if (state_q == S_STORE) begin
         mem.dmem_addr  = core_st_addr;
         mem.dmem_wdata = core_st_data;
      end
      rvfi_halt = (state_q == S_HALT);
   end

   assign core_insn      = insn_q;
   assign core_pc        = pc_q;
   assign core_regs      = regs_q;
   assign core_ld_data   = ld_data_q;
   assign rvfi_valid     = rvfi_valid_q;
   assign rvfi_order     = rvfi_order_q;
   assign rvfi_insn      = rvfi_insn_q;
   assign rvfi_pc_rdata  = rvfi_pc_rdata_q;
   assign rvfi_pc_wdata  = rvfi_pc_wdata_q;
   assign rvfi_trap      = rvfi_trap_q;
   assign rvfi_mem_addr  = rvfi_mem_addr_q;
   assign rvfi_mem_rdata = rvfi_mem_rdata_q;
   assign rvfi_mem_wdata = rvfi_mem_wdata_q;
   assign rvfi_mem_rmask = rvfi_mem_rmask_q;
   assign rvfi_mem_wmask = rvfi_mem_wmask_q;

endmodule

// File: tb/tb_rvspec_stepper.sv
// Directed bench for rvspec_stepper: the bench plays core and memories, and a
// scoreboard queue holds the retirement record each instruction must produce.
module tb_rvspec_stepper;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int sel = 0;

   logic [1:0]   arst;
   logic         imem_ready, dmem_ready;
   logic [31:0]  imem_rdata, dmem_rdata;
   logic [31:0]  core_next_pc, core_ld_addr, core_st_addr, core_st_data;
   logic [991:0] core_next_regs;
   logic         core_ld_valid, core_st_valid, core_trap;

   logic         imem_valid_w[2], dmem_valid_w[2], dmem_we_w[2];
   logic [31:0]  imem_addr_w[2], dmem_addr_w[2], dmem_wdata_w[2];
   logic [31:0]  core_insn_w[2], core_pc_w[2], core_ld_data_w[2];
   logic [991:0] core_regs_w[2];
   logic         rvfi_valid_w[2], rvfi_trap_w[2], rvfi_halt_w[2];
   logic [63:0]  rvfi_order_w[2];
   logic [31:0]  rvfi_insn_w[2], rvfi_pc_rdata_w[2], rvfi_pc_wdata_w[2];
   logic [31:0]  rvfi_mem_addr_w[2], rvfi_mem_rdata_w[2], rvfi_mem_wdata_w[2];
   logic [3:0]   rvfi_mem_rmask_w[2], rvfi_mem_wmask_w[2];

   // Instance 0 halts on trap; instance 1 restarts at 0x40.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      rvspec_stepper_if mif();
      assign mif.imem_ready   = imem_ready;
      assign mif.imem_rdata   = imem_rdata;
      assign mif.dmem_ready   = dmem_ready;
      assign mif.dmem_rdata   = dmem_rdata;
      assign imem_valid_w[g]  = mif.imem_valid;
      assign imem_addr_w[g]   = mif.imem_addr;
      assign dmem_valid_w[g]  = mif.dmem_valid;
      assign dmem_we_w[g]     = mif.dmem_we;
      assign dmem_addr_w[g]   = mif.dmem_addr;
      assign dmem_wdata_w[g]  = mif.dmem_wdata;

      rvspec_stepper #(
         .RESET_PC    (32'h0),
         .TRAP_VECTOR ((g == 0) ? 32'h0 : 32'h40),
         .HALT_ON_TRAP(g == 0),
         .ORDER_WIDTH (64)
      ) dut (
         .clk           (clk),
         .arst          (arst[g]),
         .mem           (mif),
         .core_insn     (core_insn_w[g]),
         .core_pc       (core_pc_w[g]),
         .core_regs     (core_regs_w[g]),
         .core_ld_data  (core_ld_data_w[g]),
         .core_next_pc  (core_next_pc),
         .core_next_regs(core_next_regs),
         .core_ld_valid (core_ld_valid),
         .core_st_valid (core_st_valid),
         .core_ld_addr  (core_ld_addr),
         .core_st_addr  (core_st_addr),
         .core_st_data  (core_st_data),
         .core_trap     (core_trap),
         .rvfi_valid    (rvfi_valid_w[g]),
         .rvfi_order    (rvfi_order_w[g]),
         .rvfi_insn     (rvfi_insn_w[g]),
         .rvfi_pc_rdata (rvfi_pc_rdata_w[g]),
         .rvfi_pc_wdata (rvfi_pc_wdata_w[g]),
         .rvfi_trap     (rvfi_trap_w[g]),
         .rvfi_halt     (rvfi_halt_w[g]),
         .rvfi_mem_addr (rvfi_mem_addr_w[g]),
         .rvfi_mem_rdata(rvfi_mem_rdata_w[g]),
         .rvfi_mem_wdata(rvfi_mem_wdata_w[g]),
         .rvfi_mem_rmask(rvfi_mem_rmask_w[g]),
         .rvfi_mem_wmask(rvfi_mem_wmask_w[g])
      );
   end

   typedef struct {
      logic [31:0] insn, pc_r, pc_w;
      logic        trap;
      logic [31:0] maddr;
      logic [3:0]  rmask, wmask;
      logic [31:0] rdata, wdata;
      logic [63:0] order;
   } rec_t;

   rec_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] insn, pc_r, pc_w, input logic trap,
                       input logic [31:0] maddr, input logic [3:0] rmask, wmask,
                       input logic [31:0] rdata, wdata, input logic [63:0] order);
      rec_t r;
      r.insn = insn; r.pc_r = pc_r; r.pc_w = pc_w; r.trap = trap; r.maddr = maddr;
      r.rmask = rmask; r.wmask = wmask; r.rdata = rdata; r.wdata = wdata; r.order = order;
      exp_q.push_back(r);
   endtask

   function automatic logic [31:0] xreg(input logic [991:0] r, input int k);
      return r[(31-k)*32 +: 32];
   endfunction

   function automatic logic [991:0] setx(input logic [991:0] r, input int k, input logic [31:0] v);
      r[(31-k)*32 +: 32] = v;
      return r;
   endfunction

   // Scoreboard: every retirement pulse pops and checks one expected record.
   always @(negedge clk) begin : monitor
      rec_t e;
      if (rvfi_valid_w[sel]) begin
         if (exp_q.size() == 0) begin
            chk("rvfi_unexpected", 64'(rvfi_valid_w[sel]), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rvfi_order",      rvfi_order_w[sel],          e.order);
            chk("rvfi_insn",       64'(rvfi_insn_w[sel]),      64'(e.insn));
            chk("rvfi_pc_rdata",   64'(rvfi_pc_rdata_w[sel]),  64'(e.pc_r));
            chk("rvfi_pc_wdata",   64'(rvfi_pc_wdata_w[sel]),  64'(e.pc_w));
            chk("rvfi_trap",       64'(rvfi_trap_w[sel]),      64'(e.trap));
            chk("rvfi_mem_addr",   64'(rvfi_mem_addr_w[sel]),  64'(e.maddr));
            chk("rvfi_mem_rmask",  64'(rvfi_mem_rmask_w[sel]), 64'(e.rmask));
            chk("rvfi_mem_wmask",  64'(rvfi_mem_wmask_w[sel]), 64'(e.wmask));
            chk("rvfi_mem_rdata",  64'(rvfi_mem_rdata_w[sel]), 64'(e.rdata));
            chk("rvfi_mem_wdata",  64'(rvfi_mem_wdata_w[sel]), 64'(e.wdata));
         end
      end
   end

   task automatic wait_imem(input int budget);
      int n = 0;
      while (!imem_valid_w[sel] && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("imem_valid_seen", 64'(imem_valid_w[sel]), 64'd1);
   endtask

   task automatic wait_dmem(input int budget);
      int n = 0;
      while (!dmem_valid_w[sel] && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("dmem_valid_seen", 64'(dmem_valid_w[sel]), 64'd1);
   endtask

   task automatic do_fetch(input logic [31:0] insn, input logic [31:0] addr);
      wait_imem(20);
      chk("imem_addr", 64'(imem_addr_w[sel]), 64'(addr));
      imem_rdata = insn;
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("records_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      arst = 2'b11;
      imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0; dmem_rdata = '0;
      core_next_pc = '0; core_next_regs = '0; core_ld_valid = 1'b0; core_st_valid = 1'b0;
      core_ld_addr = '0; core_st_addr = '0; core_st_data = '0; core_trap = 1'b0;

      @(negedge clk);
      chk("rst_imem_valid", 64'(imem_valid_w[0]), 64'd0);
      chk("rst_dmem_valid", 64'(dmem_valid_w[0]), 64'd0);
      chk("rst_rvfi_valid", 64'(rvfi_valid_w[0]), 64'd0);
      chk("rst_rvfi_halt",  64'(rvfi_halt_w[0]),  64'd0);
      chk("rst_pc",         64'(core_pc_w[0]),    64'd0);
      chk("rst_regs_zero",  64'(core_regs_w[0] == '0), 64'd1);
      chk("rst_insn",       64'(core_insn_w[0]),  64'd0);
      chk("rst_order",      rvfi_order_w[0],      64'd0);

      // T1: addi x1,x0,5
      core_next_pc = 32'h4;
      core_next_regs = setx('0, 1, 32'd5);
      push(32'h00500093, 32'h0, 32'h4, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd0);
      arst[0] = 1'b0;
      do_fetch(32'h00500093, 32'h0);
      chk("t1_core_insn", 64'(core_insn_w[0]), 64'h00500093);
      drain(20);
      chk("t1_x1", 64'(xreg(core_regs_w[0], 1)), 64'd5);
      chk("t1_pc", 64'(core_pc_w[0]), 64'h4);

      // addi x1,x0,0x100 to set up the load base
      core_next_pc = 32'h8;
      core_next_regs = setx('0, 1, 32'h100);
      push(32'h10000093, 32'h4, 32'h8, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd1);
      do_fetch(32'h10000093, 32'h4);
      drain(20);

      // T2: lw x2,0(x1) with three stall cycles
      core_ld_valid = 1'b1; core_ld_addr = 32'h100; dmem_rdata = 32'hDEADBEEF;
      core_next_pc = 32'hC;
      core_next_regs = setx(setx('0, 1, 32'h100), 2, 32'hDEADBEEF);
      push(32'h0000A103, 32'h8, 32'hC, 1'b0, 32'h100, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 64'd2);
      do_fetch(32'h0000A103, 32'h8);
      wait_dmem(20);
      chk("t2_we", 64'(dmem_we_w[0]), 64'd0);
      for (int i = 0; i < 3; i++) begin
         chk("t2_stall_valid", 64'(dmem_valid_w[0]), 64'd1);
         chk("t2_stall_addr",  64'(dmem_addr_w[0]),  64'h100);
         @(negedge clk);
      end
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
      drain(20);
      core_ld_valid = 1'b0;
      chk("t2_x2", 64'(xreg(core_regs_w[0], 2)), 64'hDEADBEEF);
      chk("t2_ld_data", 64'(core_ld_data_w[0]), 64'hDEADBEEF);

      // T3: sw of 0x12345678 to 0x200
      core_st_valid = 1'b1; core_st_addr = 32'h200; core_st_data = 32'h12345678;
      core_next_pc = 32'h10;
      push(32'h20202023, 32'hC, 32'h10, 1'b0, 32'h200, 4'h0, 4'hF, 32'h0, 32'h12345678, 64'd3);
      do_fetch(32'h20202023, 32'hC);
      wait_dmem(20);
      chk("t3_we",    64'(dmem_we_w[0]),    64'd1);
      chk("t3_addr",  64'(dmem_addr_w[0]),  64'h200);
      chk("t3_wdata", 64'(dmem_wdata_w[0]), 64'h12345678);
      @(negedge clk);
      chk("t3_stall_valid", 64'(dmem_valid_w[0]), 64'd1);
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
      drain(20);
      core_st_valid = 1'b0;
      chk("t3_x1", 64'(xreg(core_regs_w[0], 1)), 64'h100);
      chk("t3_x2", 64'(xreg(core_regs_w[0], 2)), 64'hDEADBEEF);
      chk("t3_pc", 64'(core_pc_w[0]), 64'h10);

      // T4: trap with HALT_ON_TRAP=1; core offers junk next state that must be ignored
      core_trap = 1'b1; core_next_pc = 32'h999; core_next_regs = '1;
      push(32'hFFFFFFFF, 32'h10, 32'h0, 1'b1, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd4);
      do_fetch(32'hFFFFFFFF, 32'h10);
      drain(20);
      core_trap = 1'b0;
      chk("t4_pc_kept", 64'(core_pc_w[0]), 64'h10);
      chk("t4_x1_kept", 64'(xreg(core_regs_w[0], 1)), 64'h100);
      for (int i = 0; i < 8; i++) begin
         chk("t4_halt",     64'(rvfi_halt_w[0]),  64'd1);
         chk("t4_no_fetch", 64'(imem_valid_w[0]), 64'd0);
         @(negedge clk);
      end

      // T6: reset clears HALT, then reset again in the middle of a load
      arst[0] = 1'b1;
      #1;
      chk("t6_halt_cleared", 64'(rvfi_halt_w[0]), 64'd0);
      @(negedge clk);
      arst[0] = 1'b0;
      core_ld_valid = 1'b1; core_ld_addr = 32'h300; core_next_pc = 32'h4;
      do_fetch(32'h0000A103, 32'h0);
      wait_dmem(20);
      chk("t6_load_addr", 64'(dmem_addr_w[0]), 64'h300);
      #2;
      arst[0] = 1'b1;
      #1;
      chk("t6_dmem_drop", 64'(dmem_valid_w[0]), 64'd0);
      chk("t6_imem_held", 64'(imem_valid_w[0]), 64'd0);
      @(negedge clk);
      chk("t6_pc_reset", 64'(core_pc_w[0]), 64'h0);
      core_ld_valid = 1'b0;
      core_next_pc = 32'h4;
      core_next_regs = setx('0, 3, 32'd7);
      push(32'h00700193, 32'h0, 32'h4, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd0);
      arst[0] = 1'b0;
      do_fetch(32'h00700193, 32'h0);
      drain(20);
      chk("t6_x3", 64'(xreg(core_regs_w[0], 3)), 64'd7);

      // T5: misaligned next pc on the restarting instance
      arst[0] = 1'b1;
      sel = 1;
      core_next_regs = '0;
      core_next_pc = 32'h6;
      push(32'h00000013, 32'h0, 32'h6, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd0);
      push(32'h00000000, 32'h6, 32'h0, 1'b1, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd1);
      @(negedge clk);
      arst[1] = 1'b0;
      do_fetch(32'h00000013, 32'h0);
      drain(20);
      wait_imem(20);
      chk("t5_restart_addr", 64'(imem_addr_w[1]), 64'h40);
      chk("t5_no_halt", 64'(rvfi_halt_w[1]), 64'd0);
      core_next_pc = 32'h44;
      push(32'h00000013, 32'h40, 32'h44, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 64'd2);
      do_fetch(32'h00000013, 32'h40);
      drain(20);
      chk("t5_pc", 64'(core_pc_w[1]), 64'h44);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
